// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle 16-bit-instruction CPU core with a parametrised datapath.
// Instructions and load data share one memory port that uses a req/ack
// handshake, so any number of memory wait states is tolerated.
module cpu_mc #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              retire
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_LI   = 4'h7,
    OP_LUI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ADDI = 4'hA,
    OP_BZ   = 4'hB,
    OP_BC   = 4'hC,
    OP_JR   = 4'hD,
    OP_CMP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ldAddr_q, ldAddr_d;
  logic [15:0]       inst_q, inst_d;
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];
  logic              zFlag_q, zFlag_d;
  logic              cFlag_q, cFlag_d;
  logic              retire_q, retire_d;

  opcode_t           op;
  logic [3:0]        rdIdx, rs1Idx, rs2Idx;
  logic [DATA_W-1:0] rs1Val, rs2Val, rdVal;
  logic [DATA_W-1:0] imm8Ext, imm4Ext;
  logic [ADDR_W-1:0] branchOff;
  logic [DATA_W:0]   addSum, addiSum;
  logic [DATA_W-1:0] diff;
  logic              borrow;

  logic [DATA_W-1:0] aluRes;
  logic              aluCarry;
  logic              aluWrite;
  logic              aluFlags;

  // Field decode and operand fetch from the latched instruction
  assign op        = opcode_t'(inst_q[15:12]);
  assign rdIdx     = inst_q[11:8];
  assign rs1Idx    = inst_q[7:4];
  assign rs2Idx    = inst_q[3:0];
  assign rs1Val    = regs_q[rs1Idx];
  assign rs2Val    = regs_q[rs2Idx];
  assign rdVal     = regs_q[rdIdx];
  assign imm8Ext   = DATA_W'($signed(inst_q[7:0]));
  assign imm4Ext   = DATA_W'($signed(inst_q[3:0]));
  assign branchOff = ADDR_W'($signed(inst_q[7:0]));

  // One extra bit on the adders exposes the carry out of the top data bit
  assign addSum  = {1'b0, rs1Val} + {1'b0, rs2Val};
  assign addiSum = {1'b0, rs1Val} + {1'b0, imm4Ext};
  assign diff    = rs1Val - rs2Val;
  assign borrow  = rs1Val < rs2Val;

  // The store revision will drive these; the load-only core keeps them idle
  assign mem_we  = 1'b0;
  assign mem_in  = '0;

  assign pc      = pc_q;
  assign halted  = (state_q == ST_HALT);
  assign retire  = retire_q;

  // ALU: result, carry and which of writeback/flag update the opcode wants
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    aluWrite = 1'b0;
    aluFlags = 1'b0;
    case (op)
      OP_ADD: begin
        aluRes   = addSum[DATA_W-1:0];
        aluCarry = addSum[DATA_W];
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_SUB: begin
        aluRes   = diff;
        aluCarry = borrow;
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_AND: begin
        aluRes   = rs1Val & rs2Val;
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_OR: begin
        aluRes   = rs1Val | rs2Val;
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_XOR: begin
        aluRes   = rs1Val ^ rs2Val;
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_SHL: begin
        aluRes   = rs1Val << rs2Val[SHW-1:0];
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_SHR: begin
        aluRes   = rs1Val >> rs2Val[SHW-1:0];
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_LI: begin
        aluRes   = imm8Ext;
        aluWrite = 1'b1;
      end
      OP_LUI: begin
        aluRes        = rdVal;
        aluRes[15:8]  = inst_q[7:0];
        aluWrite      = 1'b1;
      end
      OP_ADDI: begin
        aluRes   = addiSum[DATA_W-1:0];
        aluCarry = addiSum[DATA_W];
        aluWrite = 1'b1;
        aluFlags = 1'b1;
      end
      OP_CMP: begin
        aluRes   = diff;
        aluCarry = borrow;
        aluFlags = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sequencer: next state, architectural updates and memory port drive
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    ldAddr_d = ldAddr_q;
    regs_d   = regs_q;
    zFlag_d  = zFlag_q;
    cFlag_d  = cFlag_q;
    retire_d = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          inst_d  = mem_out[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
        if (aluWrite) begin
          regs_d[rdIdx] = aluRes;
        end
        if (aluFlags) begin
          zFlag_d = (aluRes == '0);
          cFlag_d = aluCarry;
        end
        case (op)
          OP_BZ: begin
            if (zFlag_q) pc_d = pc_q + branchOff;
          end
          OP_BC: begin
            if (cFlag_q) pc_d = pc_q + branchOff;
          end
          OP_JR: begin
            pc_d = ADDR_W'(rs1Val);
          end
          OP_LD: begin
            ldAddr_d = ADDR_W'(rs1Val);
            state_d  = ST_MEM;
            retire_d = 1'b0;
          end
          OP_HALT: begin
            state_d = ST_HALT;
          end
          default: begin
          end
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ldAddr_q;
        if (mem_ack) begin
          regs_d[rdIdx] = mem_out;
          retire_d      = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_HALT: begin
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and architectural registers; reset drops any access in flight at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      ldAddr_q <= '0;
      inst_q   <= '0;
      zFlag_q  <= 1'b0;
      cFlag_q  <= 1'b0;
      retire_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ldAddr_q <= ldAddr_d;
      inst_q   <= inst_d;
      zFlag_q  <= zFlag_d;
      cFlag_q  <= cFlag_d;
      retire_q <= retire_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed programs on three cpu_mc configurations, each with its
// own memory model; results are observed through the fetch address stream.
module tb_cpu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  // Configuration A: 16-bit data/address, programmable wait states
  logic        rstA, reqA, weA, ackA, haltA, retA;
  logic [15:0] addrA, inA, outA, pcA;
  logic [15:0] memA [256];
  int          waitA = 0;
  int          cntA;

  // Configuration B: reset PC at the top of the address space
  logic        rstB, reqB, weB, ackB, haltB, retB;
  logic [15:0] addrB, inB, outB, pcB;
  logic [15:0] memB [256];

  // Configuration C: 32-bit data and address
  logic        rstC, reqC, weC, ackC, haltC, retC;
  logic [31:0] addrC, inC, outC, pcC;
  logic [31:0] memC [1024];

  cpu_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dutA (
    .clk(clk), .rst(rstA), .mem_req(reqA), .mem_we(weA), .mem_addr(addrA),
    .mem_in(inA), .mem_out(outA), .mem_ack(ackA), .pc(pcA), .halted(haltA),
    .retire(retA));

  cpu_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'hFFFF)) dutB (
    .clk(clk), .rst(rstB), .mem_req(reqB), .mem_we(weB), .mem_addr(addrB),
    .mem_in(inB), .mem_out(outB), .mem_ack(ackB), .pc(pcB), .halted(haltB),
    .retire(retB));

  cpu_mc #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0)) dutC (
    .clk(clk), .rst(rstC), .mem_req(reqC), .mem_we(weC), .mem_addr(addrC),
    .mem_in(inC), .mem_out(outC), .mem_ack(ackC), .pc(pcC), .halted(haltC),
    .retire(retC));

  // Memory models: A acks after waitA stall cycles, B and C are zero-wait
  assign ackA = reqA && (cntA == waitA);
  assign outA = memA[addrA[7:0]];
  assign ackB = reqB;
  assign outB = memB[addrB[7:0]];
  assign ackC = reqC;
  assign outC = memC[addrC[9:0]];

  // Wait-state counter for A; a reset discards any half-finished access
  always @(posedge clk or posedge rstA) begin
    if (rstA) cntA <= 0;
    else if (!reqA || ackA) cntA <= 0;
    else cntA <= cntA + 1;
  end

  // Bus monitor: logs completed accesses and retire times, flags bad port use
  logic [31:0] accA [$];
  logic [31:0] accB [$];
  logic [31:0] accC [$];
  int          retTA [$];
  int          cyc = 0;
  int          addr40A = 0;
  int          haltReqViolA = 0;
  int          weViol = 0;

  always @(negedge clk) begin
    cyc++;
    if (rstA) begin
      accA.delete();
      retTA.delete();
      addr40A = 0;
      haltReqViolA = 0;
    end else begin
      if (reqA && ackA) accA.push_back({16'h0, addrA});
      if (retA) retTA.push_back(cyc);
      if (haltA && reqA) haltReqViolA++;
      if (reqA && addrA == 16'h0040) addr40A++;
    end
    if (rstB) accB.delete();
    else if (reqB && ackB) accB.push_back({16'h0, addrB});
    if (rstC) accC.delete();
    else if (reqC && ackC) accC.push_back(addrC);
    if (weA !== 1'b0 || inA !== 16'h0 || weB !== 1'b0 || inB !== 16'h0 ||
        weC !== 1'b0 || inC !== 32'h0) weViol++;
  end

  logic [31:0] expList [$];

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] getAcc(input int sel, input int i);
    logic [31:0] v;
    v = 32'hDEADBEEF;
    case (sel)
      0: if (i < accA.size()) v = accA[i];
      1: if (i < accB.size()) v = accB[i];
      default: if (i < accC.size()) v = accC[i];
    endcase
    return v;
  endfunction

  function automatic int accSize(input int sel);
    case (sel)
      0: return accA.size();
      1: return accB.size();
      default: return accC.size();
    endcase
  endfunction

  function automatic int retGap(input int i);
    if (i + 1 < retTA.size()) return retTA[i+1] - retTA[i];
    return -1;
  endfunction

  // Compare the logged access stream against expList, optionally its length too
  task automatic checkAcc(input int sel, input string tag, input bit exact);
    if (exact) checkOutput({tag, " count"}, accSize(sel), expList.size());
    for (int i = 0; i < expList.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), getAcc(sel, i), expList[i]);
    end
  endtask

  // Bounded wait for n logged accesses; running out of budget is a miscompare
  task automatic waitAcc(input int sel, input int n, input int budget);
    int c;
    c = 0;
    while (accSize(sel) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput($sformatf("access budget sel%0d", sel), (accSize(sel) >= n), 1'b1);
  endtask

  // Restart core A with the given memory wait states
  task automatic applyStimulus(input int waitCycles);
    rstA  = 1'b1;
    waitA = waitCycles;
    repeat (2) @(negedge clk);
    rstA  = 1'b0;
  endtask

  task automatic clearMemA();
    for (int i = 0; i < 256; i++) memA[i] = 16'hF000;
  endtask

  initial begin
    int c;
    rstA = 1'b1;
    rstB = 1'b1;
    rstC = 1'b1;
    clearMemA();
    for (int i = 0; i < 256; i++) memB[i] = 16'hF000;
    for (int i = 0; i < 1024; i++) memC[i] = 32'h0000F000;

    // Reset values
    @(negedge clk);
    checkOutput("rst mem_req", reqA, 1'b0);
    checkOutput("rst mem_we", weA, 1'b0);
    checkOutput("rst mem_addr", addrA, 16'h0);
    checkOutput("rst mem_in", inA, 16'h0);
    checkOutput("rst pc", pcA, 16'h0);
    checkOutput("rst halted", haltA, 1'b0);
    checkOutput("rst retire", retA, 1'b0);
    checkOutput("rst pc B", pcB, 16'hFFFF);

    // LI r1,5; LI r2,-3; ADD r3,r1,r2; HALT
    memA[0] = 16'h7105;
    memA[1] = 16'h72FD;
    memA[2] = 16'h0312;
    memA[3] = 16'hF000;
    applyStimulus(0);
    c = 0;
    while (!reqA && c < 10) begin
      @(negedge clk);
      c++;
    end
    checkOutput("boot to fetch cycles", c, 1);
    c = 0;
    while (!haltA && c < 50) begin
      @(negedge clk);
      c++;
    end
    checkOutput("cycles to halted", c, 8);
    repeat (4) @(negedge clk);
    checkOutput("halted stays", haltA, 1'b1);
    checkOutput("retire pulses", retTA.size(), 4);
    checkOutput("req while halted", haltReqViolA, 0);
    expList = '{32'h0, 32'h1, 32'h2, 32'h3};
    checkAcc(0, "prog1", 1'b1);

    // Same arithmetic, then BZ (not taken), BC (taken) and JR r3 exposing r3=2
    clearMemA();
    memA[0] = 16'h7105;
    memA[1] = 16'h72FD;
    memA[2] = 16'h0312;
    memA[3] = 16'hB005;
    memA[4] = 16'hC001;
    memA[6] = 16'hD030;
    applyStimulus(0);
    waitAcc(0, 7, 60);
    expList = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h6, 32'h2};
    checkAcc(0, "add flags", 1'b0);

    // SUB r4,r1,r1 sets Z; BZ +2 taken; BC +3 not taken with C=0
    clearMemA();
    memA[0] = 16'h7105;
    memA[1] = 16'h1411;
    memA[2] = 16'hB002;
    memA[5] = 16'hC003;
    applyStimulus(0);
    waitAcc(0, 5, 40);
    repeat (4) @(negedge clk);
    expList = '{32'h0, 32'h1, 32'h2, 32'h5, 32'h6};
    checkAcc(0, "branch", 1'b1);
    checkOutput("branch retires", retTA.size(), 5);

    // LD r5,[r1] with three wait states, then JR r5 exposes the loaded value
    clearMemA();
    memA[0]     = 16'h7140;
    memA[1]     = 16'h9510;
    memA[2]     = 16'hD050;
    memA[8'h40] = 16'h0020;
    applyStimulus(3);
    waitAcc(0, 5, 80);
    repeat (3) @(negedge clk);
    expList = '{32'h0, 32'h1, 32'h40, 32'h2, 32'h20};
    checkAcc(0, "load", 1'b1);
    checkOutput("ld addr held cycles", addr40A, 4);
    checkOutput("ld latency", retGap(0), 9);
    checkOutput("jr latency waits", retGap(1), 5);
    checkOutput("load halted", haltA, 1'b1);

    // Reset while LD is waiting in MEM, then check registers were cleared
    clearMemA();
    memA[0]     = 16'h7140;
    memA[1]     = 16'h9510;
    memA[8'h40] = 16'h0020;
    applyStimulus(5);
    c = 0;
    while (!(reqA && addrA == 16'h0040) && c < 60) begin
      @(negedge clk);
      c++;
    end
    checkOutput("reached mem state", (reqA && addrA == 16'h0040), 1'b1);
    #2;
    rstA = 1'b1;
    #1;
    checkOutput("async rst mem_req", reqA, 1'b0);
    checkOutput("async rst pc", pcA, 16'h0);
    clearMemA();
    memA[0] = 16'hD010;
    repeat (2) @(negedge clk);
    rstA = 1'b0;
    #1;
    checkOutput("boot after rst", reqA, 1'b0);
    @(negedge clk);
    checkOutput("fetch after boot req", reqA, 1'b1);
    checkOutput("fetch after boot addr", addrA, 16'h0);
    waitAcc(0, 3, 60);
    expList = '{32'h0, 32'h0, 32'h0};
    checkAcc(0, "regs cleared", 1'b0);

    // PC wrap from 16'hFFFF to 0
    memB[8'hFF] = 16'h7101;
    @(negedge clk);
    rstB = 1'b0;
    waitAcc(1, 2, 20);
    repeat (4) @(negedge clk);
    expList = '{32'hFFFF, 32'h0};
    checkAcc(1, "pc wrap", 1'b1);
    checkOutput("pc wrap halted", haltB, 1'b1);

    // 32-bit: LI r1,-1; LUI r1,12; JR r1; ADDI r1,r1,1; BC +1; JR r1
    memC[0]      = 32'h71FF;
    memC[1]      = 32'h8112;
    memC[2]      = 32'hD010;
    memC[10'h2FF] = 32'hA111;
    memC[10'h300] = 32'hC001;
    memC[10'h301] = 32'hD010;
    @(negedge clk);
    rstC = 1'b0;
    waitAcc(2, 7, 60);
    expList = '{32'h0, 32'h1, 32'h2, 32'hFFFF12FF, 32'hFFFF1300,
                32'hFFFF1301, 32'hFFFF1300};
    checkAcc(2, "wide", 1'b0);

    checkOutput("mem_we/mem_in idle", weViol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
